// File: rtl/pcx2mb_grant_ctl_if.sv
// pcx2mb_grant_ctl_if: PCX request/data/grant plus downstream valid/ready packet bus.
// Latency: none, signal bundle only.
// Backpressure: mb_req_ready from downstream stalls the presented packet.
interface pcx2mb_grant_ctl_if #(
    parameter int PKT_W = 124
);
    logic             pcx_req_pq;
    logic             pcx_atom_pq;
    logic [PKT_W-1:0] pcx_data_pa;
    logic             pcx_grant_px;
    logic             mb_req_valid;
    logic             mb_req_ready;
    logic [PKT_W-1:0] mb_req_data;
    logic             mb_req_atom;
    logic [7:0]       drop_count;

    // Upstream/downstream environment side.
    modport master (
        output pcx_req_pq, pcx_atom_pq, pcx_data_pa, mb_req_ready,
        input  pcx_grant_px, mb_req_valid, mb_req_data, mb_req_atom, drop_count
    );

    // Grant controller side.
    modport slave (
        input  pcx_req_pq, pcx_atom_pq, pcx_data_pa, mb_req_ready,
        output pcx_grant_px, mb_req_valid, mb_req_data, mb_req_atom, drop_count
    );
endinterface

// File: rtl/pcx2mb_grant_ctl.sv
// pcx2mb_grant_ctl: 2-entry credit-matched buffer between PCX and a valid/ready sink.
// Latency: PQ request -> packet visible at PA+1 -> grant one cycle after the pop.
// Backpressure: requests beyond the 2-entry reservation are dropped; PCX_DROP counter
// is built only when PCX2MB_DROP_CNT_EN is defined (else drop_count is tied to 0).
module pcx2mb_grant_ctl #(
    parameter int PKT_W = 124
) (
    input  logic              rclk,
    input  logic              reset,
    pcx2mb_grant_ctl_if.slave bus
);
    typedef struct packed {
        logic             atom;
        logic [PKT_W-1:0] data;
    } entry_t;

    entry_t     r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_stored;
    logic [1:0] r_resv;
    logic       r_wr_pa;
    logic       r_atom_pa;
    logic       r_wr_pa1;
    logic       r_grant;

    logic       w_pop;
    logic       w_wr;
    logic       w_atom2_pend;
    logic       w_acc_one;
    logic       w_acc_two;
    logic [1:0] w_resv_avail;
    logic [1:0] w_resv_add;
    entry_t     w_wr_entry;

    // A pop frees its slot in the same cycle, so a full buffer can still accept.
    assign w_pop        = (r_stored != 2'd0) && bus.mb_req_ready;
    assign w_resv_avail = r_resv - {1'b0, w_pop};

    // While an atomic pair is still being written, new requests are refused outright.
    assign w_atom2_pend = (r_wr_pa && r_atom_pa) || r_wr_pa1;
    assign w_acc_one    = bus.pcx_req_pq && !bus.pcx_atom_pq && !w_atom2_pend
                          && (w_resv_avail <= 2'd1);
    assign w_acc_two    = bus.pcx_req_pq && bus.pcx_atom_pq && !w_atom2_pend
                          && (w_resv_avail == 2'd0);
    assign w_resv_add   = w_acc_two ? 2'd2 : {1'b0, w_acc_one};

    // PA carries the first packet (atom flag from the request), PA+1 the atomic tail.
    assign w_wr         = r_wr_pa || r_wr_pa1;
    assign w_wr_entry   = {r_wr_pa && r_atom_pa, bus.pcx_data_pa};

    // Reservation count and the PQ -> PA -> PA+1 write pipeline.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_resv    <= 2'd0;
            r_wr_pa   <= 1'b0;
            r_atom_pa <= 1'b0;
            r_wr_pa1  <= 1'b0;
        end else begin
            r_resv    <= w_resv_avail + w_resv_add;
            r_wr_pa   <= w_acc_one || w_acc_two;
            r_atom_pa <= w_acc_two;
            r_wr_pa1  <= r_wr_pa && r_atom_pa;
        end
    end

    // Two-entry storage with wrapping pointers and occupancy.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_stored <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_wr_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_stored <= r_stored + {1'b0, w_wr} - {1'b0, w_pop};
        end
    end

    // Grant returns the credit one cycle after the packet leaves.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_grant <= 1'b0;
        end else begin
            r_grant <= w_pop;
        end
    end

    assign bus.pcx_grant_px = r_grant;
    assign bus.mb_req_valid = (r_stored != 2'd0);
    assign bus.mb_req_data  = r_mem[r_rd_ptr].data;
    assign bus.mb_req_atom  = r_mem[r_rd_ptr].atom;

`ifdef PCX2MB_DROP_CNT_EN
    logic       w_drop;
    logic [7:0] r_drop_cnt;

    // An atomic pair that is refused counts as a single drop.
    assign w_drop = bus.pcx_req_pq && !(w_acc_one || w_acc_two);

    // Saturating count of refused requests.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.drop_count = r_drop_cnt;
`else
    assign bus.drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_pcx2mb_grant_ctl.sv
// tb_pcx2mb_grant_ctl: directed checks of acceptance, ordering, grants, drops and reset.
// Latency: inputs driven 2 time units after each rising edge, outputs checked there too.
// Backpressure: mb_req_ready is steered per step to fill and drain the buffer.
module tb_pcx2mb_grant_ctl;
    localparam int PKT_W = 124;

    logic rclk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   drops  = 0;

    pcx2mb_grant_ctl_if #(.PKT_W(PKT_W)) bus ();

    pcx2mb_grant_ctl #(.PKT_W(PKT_W)) dut (
        .rclk  (rclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_drop();
`ifdef PCX2MB_DROP_CNT_EN
        return (drops > 255) ? 128'd255 : 128'(drops);
`else
        return 128'd0;
`endif
    endfunction

    function automatic logic [PKT_W-1:0] pk(input logic [7:0] n);
        return {n[3:0], 56'h0, ~n, 48'h0, n};
    endfunction

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    initial begin
        reset            = 1'b1;
        bus.pcx_req_pq   = 1'b0;
        bus.pcx_atom_pq  = 1'b0;
        bus.pcx_data_pa  = '0;
        bus.mb_req_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_valid", 128'(bus.mb_req_valid), 128'd0);
        chk("rst_grant", 128'(bus.pcx_grant_px), 128'd0);
        chk("rst_atom",  128'(bus.mb_req_atom),  128'd0);
        chk("rst_data",  128'(bus.mb_req_data),  128'd0);
        chk("rst_drop",  128'(bus.drop_count),   128'd0);
        reset = 1'b0;

        // Single request, ready=1
        tick(); bus.mb_req_ready = 1'b1; bus.pcx_req_pq = 1'b1;
        tick(); bus.pcx_req_pq = 1'b0; bus.pcx_data_pa = pk(8'h01);
        chk("t1_valid_pa", 128'(bus.mb_req_valid), 128'd0);
        tick(); bus.pcx_data_pa = pk(8'hEE);
        chk("t1_valid", 128'(bus.mb_req_valid), 128'd1);
        chk("t1_data",  128'(bus.mb_req_data),  128'(pk(8'h01)));
        chk("t1_atom",  128'(bus.mb_req_atom),  128'd0);
        chk("t1_nogrant", 128'(bus.pcx_grant_px), 128'd0);
        tick();
        chk("t1_grant", 128'(bus.pcx_grant_px), 128'd1);
        chk("t1_empty", 128'(bus.mb_req_valid), 128'd0);
        tick();
        chk("t1_one_grant", 128'(bus.pcx_grant_px), 128'd0);
        chk("t1_ignored",   128'(bus.mb_req_valid), 128'd0);

        // Three back-to-back requests with ready=0
        tick(); bus.mb_req_ready = 1'b0; bus.pcx_req_pq = 1'b1;
        tick(); bus.pcx_data_pa = pk(8'h02);
        tick(); bus.pcx_data_pa = pk(8'h03);
        chk("t2_valid", 128'(bus.mb_req_valid), 128'd1);
        chk("t2_data",  128'(bus.mb_req_data),  128'(pk(8'h02)));
        tick(); bus.pcx_req_pq = 1'b0; bus.pcx_data_pa = pk(8'h04); drops++;
        chk("t2_drop", 128'(bus.drop_count), exp_drop());
        tick(); tick();
        chk("t2_hold_valid", 128'(bus.mb_req_valid), 128'd1);
        chk("t2_hold_data",  128'(bus.mb_req_data),  128'(pk(8'h02)));
        chk("t2_hold_grant", 128'(bus.pcx_grant_px), 128'd0);
        bus.mb_req_ready = 1'b1;
        tick();
        chk("t2_grant1", 128'(bus.pcx_grant_px), 128'd1);
        chk("t2_data2",  128'(bus.mb_req_data),  128'(pk(8'h03)));
        chk("t2_valid2", 128'(bus.mb_req_valid), 128'd1);
        tick();
        chk("t2_grant2", 128'(bus.pcx_grant_px), 128'd1);
        chk("t2_empty",  128'(bus.mb_req_valid), 128'd0);
        tick();
        chk("t2_no_grant3", 128'(bus.pcx_grant_px), 128'd0);

        // Atomic into empty buffer, plus a request during the pending tail write
        tick(); bus.mb_req_ready = 1'b0; bus.pcx_req_pq = 1'b1; bus.pcx_atom_pq = 1'b1;
        tick(); bus.pcx_atom_pq = 1'b0; bus.pcx_data_pa = pk(8'h05);
        tick(); bus.pcx_req_pq = 1'b0; bus.pcx_data_pa = pk(8'h06); drops++;
        chk("t3_supp_drop", 128'(bus.drop_count), exp_drop());
        chk("t3_valid", 128'(bus.mb_req_valid), 128'd1);
        chk("t3_data1", 128'(bus.mb_req_data),  128'(pk(8'h05)));
        chk("t3_atom1", 128'(bus.mb_req_atom),  128'd1);
        tick();
        chk("t3_hold_data1", 128'(bus.mb_req_data), 128'(pk(8'h05)));
        bus.mb_req_ready = 1'b1;
        tick();
        chk("t3_grant1", 128'(bus.pcx_grant_px), 128'd1);
        chk("t3_data2",  128'(bus.mb_req_data),  128'(pk(8'h06)));
        chk("t3_atom2",  128'(bus.mb_req_atom),  128'd0);
        chk("t3_valid2", 128'(bus.mb_req_valid), 128'd1);
        tick(); bus.mb_req_ready = 1'b0;
        chk("t3_grant2", 128'(bus.pcx_grant_px), 128'd1);
        chk("t3_empty",  128'(bus.mb_req_valid), 128'd0);
        tick(); bus.pcx_req_pq = 1'b1;
        chk("t3_no_grant3", 128'(bus.pcx_grant_px), 128'd0);
        tick(); bus.pcx_req_pq = 1'b0; bus.pcx_data_pa = pk(8'h07);
        tick(); bus.pcx_req_pq = 1'b1; bus.pcx_atom_pq = 1'b1;
        tick(); bus.pcx_req_pq = 1'b0; bus.pcx_atom_pq = 1'b0; bus.pcx_data_pa = pk(8'hEE); drops++;
        chk("t3_atom_drop", 128'(bus.drop_count), exp_drop());
        chk("t3_occ_data",  128'(bus.mb_req_data), 128'(pk(8'h07)));
        chk("t3_occ_atom",  128'(bus.mb_req_atom), 128'd0);
        bus.mb_req_ready = 1'b1;
        tick();
        chk("t3_occ_grant", 128'(bus.pcx_grant_px), 128'd1);
        chk("t3_occ_empty", 128'(bus.mb_req_valid), 128'd0);
        tick(); bus.mb_req_ready = 1'b0;
        chk("t3_occ_one_grant", 128'(bus.pcx_grant_px), 128'd0);

        // Full reservation, pop and new request in the same cycle
        tick(); bus.pcx_req_pq = 1'b1;
        tick(); bus.pcx_data_pa = pk(8'h08);
        tick(); bus.pcx_req_pq = 1'b0; bus.pcx_data_pa = pk(8'h09);
        chk("t4_data_h", 128'(bus.mb_req_data), 128'(pk(8'h08)));
        tick(); bus.pcx_req_pq = 1'b1; bus.mb_req_ready = 1'b1;
        chk("t4_full_data", 128'(bus.mb_req_data), 128'(pk(8'h08)));
        tick(); bus.pcx_req_pq = 1'b0; bus.pcx_data_pa = pk(8'h0A);
        chk("t4_grant_h", 128'(bus.pcx_grant_px), 128'd1);
        chk("t4_data_i",  128'(bus.mb_req_data),  128'(pk(8'h09)));
        tick();
        chk("t4_grant_i", 128'(bus.pcx_grant_px), 128'd1);
        chk("t4_data_j",  128'(bus.mb_req_data),  128'(pk(8'h0A)));
        chk("t4_valid_j", 128'(bus.mb_req_valid), 128'd1);
        chk("t4_no_drop", 128'(bus.drop_count),   exp_drop());
        tick(); bus.mb_req_ready = 1'b0;
        chk("t4_grant_j", 128'(bus.pcx_grant_px), 128'd1);
        chk("t4_empty",   128'(bus.mb_req_valid), 128'd0);
        tick();
        chk("t4_grant_end", 128'(bus.pcx_grant_px), 128'd0);

        // Reset mid-operation with one stored and one reserved
        tick(); bus.pcx_req_pq = 1'b1;
        tick(); bus.pcx_data_pa = pk(8'h0B);
        tick(); bus.pcx_req_pq = 1'b0; bus.pcx_data_pa = pk(8'h0C);
        chk("t5_pre_data", 128'(bus.mb_req_data), 128'(pk(8'h0B)));
        chk("t5_pre_drop", 128'(bus.drop_count),  exp_drop());
        #1 reset = 1'b1;
        #1;
        drops = 0;
        chk("t5_rst_valid", 128'(bus.mb_req_valid), 128'd0);
        chk("t5_rst_data",  128'(bus.mb_req_data),  128'd0);
        chk("t5_rst_atom",  128'(bus.mb_req_atom),  128'd0);
        chk("t5_rst_grant", 128'(bus.pcx_grant_px), 128'd0);
        chk("t5_rst_drop",  128'(bus.drop_count),   128'd0);
        tick(); tick();
        reset = 1'b0; bus.mb_req_ready = 1'b1; bus.pcx_data_pa = pk(8'h0D);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_post_grant", 128'(bus.pcx_grant_px), 128'd0);
            chk("t5_post_valid", 128'(bus.mb_req_valid), 128'd0);
        end
        chk("t5_post_drop", 128'(bus.drop_count), 128'd0);

        // 300 drops: saturation or tie-off
        tick(); bus.mb_req_ready = 1'b0; bus.pcx_req_pq = 1'b1;
        tick(); bus.pcx_data_pa = pk(8'h0E);
        tick(); bus.pcx_data_pa = pk(8'h0F);
        repeat (10) tick();
        drops += 10;
        chk("t6_drop10", 128'(bus.drop_count), exp_drop());
        repeat (290) tick();
        bus.pcx_req_pq = 1'b0;
        drops += 290;
        chk("t6_drop300", 128'(bus.drop_count), exp_drop());
        chk("t6_data",    128'(bus.mb_req_data), 128'(pk(8'h0E)));
        tick();
        chk("t6_drop_hold", 128'(bus.drop_count), exp_drop());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
